instr_check_monitor: RTL and testbench

//  Synthesisable, multi-channel bus-protocol monitor. It sits beside the controller/memory pair and snoops IR, uPC, RW and Address.

---
 rtl/instr_check_monitor.sv | 231 +++++++++++++++++++++++
 tb/tb_instr_check_monitor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_check_monitor.sv
// ---------------------------------------------------------------------------
// instr_check_monitor
//   Passive multi-channel bus-protocol monitor. It snoops the controller's
//   IR / uPC and the bus RW / address. Each channel watches one opcode at one
//   micro-step and checks RW against an expected level. It keeps saturating
//   pass/fail counts per channel and captures the context of the first
//   failure.
//
//   Optional feature: define MON_WATCHDOG_EN to build an idle watchdog that
//   raises a sticky wd_tmo_o after WD_CYC cycles without any channel match.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   ir_i         controller instruction register (opcode in the top OPC_W bits)
//   upc_i        controller micro-step counter
//   rw_i         bus direction, 1 = read, 0 = write
//   address_i    bus address
//   clr_i        synchronous clear of counters, error capture and watchdog
//   cfg_we_i     write configuration of channel cfg_sel_i
//   cfg_sel_i    channel index for cfg_we_i (out-of-range writes are dropped)
//   cfg_en_i     channel enable value
//   cfg_opc_i    opcode to match
//   cfg_step_i   uPC value to match
//   cfg_rw_i     expected rw level
//   rd_sel_i     readout channel select
//   rd_pass_o    pass count of channel rd_sel_i (0 if out of range)
//   rd_fail_o    fail count of channel rd_sel_i (0 if out of range)
//   err_o        sticky: a check has failed
//   err_chan_o   lowest failing channel of the first failure
//   err_addr_o   address captured at the first failure
//   wd_tmo_o     sticky watchdog timeout (constant 0 without MON_WATCHDOG_EN)
// ---------------------------------------------------------------------------
module instr_check_monitor #(
  parameter int N      = 16,
  parameter int M      = 3,
  parameter int OPC_W  = 4,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int WD_CYC = 64,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     ir_i,
  input  logic [M-1:0]     upc_i,
  input  logic             rw_i,
  input  logic [N-1:0]     address_i,
  input  logic             clr_i,
  input  logic             cfg_we_i,
  input  logic [SEL_W-1:0] cfg_sel_i,
  input  logic             cfg_en_i,
  input  logic [OPC_W-1:0] cfg_opc_i,
  input  logic [M-1:0]     cfg_step_i,
  input  logic             cfg_rw_i,
  input  logic [SEL_W-1:0] rd_sel_i,
  output logic [CNT_W-1:0] rd_pass_o,
  output logic [CNT_W-1:0] rd_fail_o,
  output logic             err_o,
  output logic [SEL_W-1:0] err_chan_o,
  output logic [N-1:0]     err_addr_o,
  output logic             wd_tmo_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [OPC_W-1:0]              opc_field;
  logic [NUM_CH-1:0]             en_all;
  logic [NUM_CH-1:0]             match;
  logic [NUM_CH-1:0]             fail_hit;
  logic [NUM_CH-1:0][CNT_W-1:0]  pass_all;
  logic [NUM_CH-1:0][CNT_W-1:0]  fail_all;

  assign opc_field = ir_i[N-1:N-OPC_W];

  // Lower IR bits carry operands the monitor does not look at.
  logic unused_ir;
  assign unused_ir = ^ir_i[N-OPC_W-1:0];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [SEL_W-1:0] IDX = SEL_W'(gi);

    logic             en_q;
    logic [OPC_W-1:0] opc_q;
    logic [M-1:0]     step_q;
    logic             rw_exp_q;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             cfg_hit;

    // Match uses the registered configuration, so a same-cycle write only
    // takes effect from the next cycle on.
    assign match[gi]    = en_q && (opc_field == opc_q) && (upc_i == step_q);
    assign fail_hit[gi] = match[gi] && (rw_i != rw_exp_q);
    // An out-of-range cfg_sel_i equals no IDX, so the write is dropped.
    assign cfg_hit      = cfg_we_i && (cfg_sel_i == IDX);
    assign en_all[gi]   = en_q;
    assign pass_all[gi] = pass_q;
    assign fail_all[gi] = fail_q;

    always_comb begin
      pass_d = pass_q;
      fail_d = fail_q;
      if (clr_i) begin
        pass_d = '0;
        fail_d = '0;
      end else if (fail_hit[gi]) begin
        if (fail_q != CNT_MAX) fail_d = fail_q + 1'b1;
      end else if (match[gi]) begin
        if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        en_q     <= 1'b0;
        opc_q    <= '0;
        step_q   <= '0;
        rw_exp_q <= 1'b0;
        pass_q   <= '0;
        fail_q   <= '0;
      end else begin
        if (cfg_hit) begin
          en_q     <= cfg_en_i;
          opc_q    <= cfg_opc_i;
          step_q   <= cfg_step_i;
          rw_exp_q <= cfg_rw_i;
        end
        pass_q <= pass_d;
        fail_q <= fail_d;
      end
    end
  end

  // First-failure capture
  logic             err_q, err_d;
  logic [SEL_W-1:0] err_chan_q, err_chan_d;
  logic [N-1:0]     err_addr_q, err_addr_d;
  logic [SEL_W-1:0] first_idx;

  always_comb begin
    first_idx = '0;
    // Walk downward so the lowest failing index is the one left standing.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fail_hit[i]) first_idx = SEL_W'(i);
    end
    err_d      = err_q;
    err_chan_d = err_chan_q;
    err_addr_d = err_addr_q;
    if (clr_i) begin
      err_d      = 1'b0;
      err_chan_d = '0;
      err_addr_d = '0;
    end else if (!err_q && (|fail_hit)) begin
      err_d      = 1'b1;
      err_chan_d = first_idx;
      err_addr_d = address_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q      <= 1'b0;
      err_chan_q <= '0;
      err_addr_q <= '0;
    end else begin
      err_q      <= err_d;
      err_chan_q <= err_chan_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_o      = err_q;
  assign err_chan_o = err_chan_q;
  assign err_addr_o = err_addr_q;

  // Readout mux; unmatched selects read back zero.
  always_comb begin
    rd_pass_o = '0;
    rd_fail_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel_i == SEL_W'(i)) begin
        rd_pass_o = pass_all[i];
        rd_fail_o = fail_all[i];
      end
    end
  end

`ifdef MON_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYC + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(WD_CYC);

  logic [WD_W-1:0] idle_q, idle_d;
  logic            wd_q, wd_d;

  // Idle counter holds at WD_LIM so it can never wrap back to zero.
  always_comb begin
    idle_d = idle_q;
    wd_d   = wd_q;
    if (clr_i) begin
      idle_d = '0;
      wd_d   = 1'b0;
    end else begin
      if (|match) begin
        idle_d = '0;
      end else if ((|en_all) && (idle_q != WD_LIM)) begin
        idle_d = idle_q + 1'b1;
      end
      if (idle_d == WD_LIM) wd_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_q <= '0;
      wd_q   <= 1'b0;
    end else begin
      idle_q <= idle_d;
      wd_q   <= wd_d;
    end
  end

  assign wd_tmo_o = wd_q;
`else
  // Without the watchdog the enable vector and limit have no consumer.
  logic unused_wd;
  assign unused_wd = (^en_all) ^ (WD_CYC > 0);
  assign wd_tmo_o  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_check_monitor.sv
// ---------------------------------------------------------------------------
// tb_instr_check_monitor
//   Table of single-cycle vectors with hand-derived expectations, pushed into
//   a scoreboard queue when driven and popped after the clock edge, followed
//   by hand-written sequences for saturation, clear, mid-stream reset and the
//   watchdog.
// ---------------------------------------------------------------------------
module tb_instr_check_monitor;

  localparam logic [3:0] LD  = 4'h1;
  localparam logic [3:0] ST  = 4'h2;
  localparam logic [3:0] NOP = 4'hF;
`ifdef MON_WATCHDOG_EN
  localparam logic WD_EXP = 1'b1;
`else
  localparam logic WD_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ir;
  logic [2:0]  upc;
  logic        rw;
  logic [15:0] address;
  logic        clr;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic        cfg_en;
  logic [3:0]  cfg_opc;
  logic [2:0]  cfg_step;
  logic        cfg_rw;
  logic [1:0]  rd_sel;
  logic [7:0]  rd_pass;
  logic [7:0]  rd_fail;
  logic        err;
  logic [1:0]  err_chan;
  logic [15:0] err_addr;
  logic        wd_tmo;

  instr_check_monitor dut (
    .clk_i(clk), .rst_ni(rst_n), .ir_i(ir), .upc_i(upc), .rw_i(rw),
    .address_i(address), .clr_i(clr), .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel),
    .cfg_en_i(cfg_en), .cfg_opc_i(cfg_opc), .cfg_step_i(cfg_step),
    .cfg_rw_i(cfg_rw), .rd_sel_i(rd_sel), .rd_pass_o(rd_pass),
    .rd_fail_o(rd_fail), .err_o(err), .err_chan_o(err_chan),
    .err_addr_o(err_addr), .wd_tmo_o(wd_tmo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        clr;
    logic        we;
    logic [1:0]  sel;
    logic        en;
    logic [3:0]  copc;
    logic [2:0]  cstep;
    logic        crw;
    logic [3:0]  opc;
    logic [2:0]  upc;
    logic        rw;
    logic [15:0] addr;
    logic [1:0]  rsel;
    logic [7:0]  e_pass;
    logic [7:0]  e_fail;
    logic        e_err;
    logic [1:0]  e_chan;
    logic [15:0] e_addr;
  } vec_t;

  typedef struct {
    logic [7:0]  pass;
    logic [7:0]  fail;
    logic        err;
    logic [1:0]  chan;
    logic [15:0] addr;
    string       tag;
  } exp_t;

  localparam int NV = 21;
  vec_t vec [NV];
  exp_t sb_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] p, input logic [7:0] f, input logic e,
                      input logic [1:0] c, input logic [15:0] a, input string tag);
    exp_t x;
    x.pass = p; x.fail = f; x.err = e; x.chan = c; x.addr = a; x.tag = tag;
    sb_q.push_back(x);
  endtask

  task automatic compare_head();
    exp_t x;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    x = sb_q.pop_front();
    check({x.tag, ".rd_pass"},  rd_pass,  x.pass);
    check({x.tag, ".rd_fail"},  rd_fail,  x.fail);
    check({x.tag, ".err"},      err,      x.err);
    check({x.tag, ".err_chan"}, err_chan, x.chan);
    check({x.tag, ".err_addr"}, err_addr, x.addr);
    $display("%s: sel=%0d pass=%0d fail=%0d err=%0b chan=%0d addr=0x%04h",
             x.tag, rd_sel, rd_pass, rd_fail, err, err_chan, err_addr);
  endtask

  task automatic idle_in();
    clr = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_en = 1'b0;
    cfg_opc = 4'h0; cfg_step = 3'd0; cfg_rw = 1'b0;
    ir = {NOP, 12'h000}; upc = 3'd0; rw = 1'b1; address = 16'h0000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bus(input logic [3:0] o, input logic [2:0] u, input logic r,
                           input logic [15:0] a);
    ir = {o, 12'hA5C}; upc = u; rw = r; address = a;
  endtask

  task automatic drive_cfg(input logic [1:0] s, input logic e, input logic [3:0] o,
                           input logic [2:0] st, input logic r);
    cfg_we = 1'b1; cfg_sel = s; cfg_en = e; cfg_opc = o; cfg_step = st; cfg_rw = r;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".rd_pass"},  rd_pass,  0);
    check({tag, ".rd_fail"},  rd_fail,  0);
    check({tag, ".err"},      err,      0);
    check({tag, ".err_chan"}, err_chan, 0);
    check({tag, ".err_addr"}, err_addr, 0);
    check({tag, ".wd_tmo"},   wd_tmo,   0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish within time limit");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // clr we sel en copc cstep crw | opc upc rw addr | rsel | pass fail err chan addr
    vec[0]  = '{1'b0, 1'b1, 2'd0, 1'b1, ST,   3'd3, 1'b0, NOP, 3'd0, 1'b1, 16'h0000, 2'd0, 8'd0, 8'd0, 1'b0, 2'd0, 16'h0000};
    for (int k = 1; k <= 5; k++)
      vec[k] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 3'd0, 1'b0, ST,  3'd3, 1'b0, 16'h0010, 2'd0, 8'(k), 8'd0, 1'b0, 2'd0, 16'h0000};
    vec[6]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 3'd0, 1'b0, ST,  3'd2, 1'b0, 16'h0020, 2'd0, 8'd5, 8'd0, 1'b0, 2'd0, 16'h0000};
    vec[7]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 3'd0, 1'b0, LD,  3'd3, 1'b0, 16'h0030, 2'd0, 8'd5, 8'd0, 1'b0, 2'd0, 16'h0000};
    vec[8]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 3'd0, 1'b0, ST,  3'd3, 1'b1, 16'h0040, 2'd0, 8'd5, 8'd1, 1'b1, 2'd0, 16'h0040};
    vec[9]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 3'd0, 1'b0, ST,  3'd3, 1'b1, 16'h0080, 2'd0, 8'd5, 8'd2, 1'b1, 2'd0, 16'h0040};
    vec[10] = '{1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 3'd0, 1'b0, NOP, 3'd0, 1'b1, 16'h0000, 2'd0, 8'd0, 8'd0, 1'b0, 2'd0, 16'h0000};
    vec[11] = '{1'b0, 1'b1, 2'd1, 1'b1, LD,   3'd2, 1'b1, NOP, 3'd0, 1'b1, 16'h0000, 2'd1, 8'd0, 8'd0, 1'b0, 2'd0, 16'h0000};
    vec[12] = '{1'b0, 1'b1, 2'd2, 1'b1, LD,   3'd2, 1'b0, NOP, 3'd0, 1'b1, 16'h0000, 2'd1, 8'd0, 8'd0, 1'b0, 2'd0, 16'h0000};
    vec[13] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 3'd0, 1'b0, LD,  3'd2, 1'b1, 16'h0123, 2'd1, 8'd1, 8'd0, 1'b1, 2'd2, 16'h0123};
    vec[14] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 3'd0, 1'b0, NOP, 3'd0, 1'b1, 16'h0000, 2'd2, 8'd0, 8'd1, 1'b1, 2'd2, 16'h0123};
    vec[15] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 3'd0, 1'b0, NOP, 3'd0, 1'b1, 16'h0000, 2'd0, 8'd0, 8'd0, 1'b1, 2'd2, 16'h0123};
    // Reconfigure ch0 while it matches: this edge still uses rw_exp=0.
    vec[16] = '{1'b0, 1'b1, 2'd0, 1'b1, ST,   3'd3, 1'b1, ST,  3'd3, 1'b0, 16'h0200, 2'd0, 8'd1, 8'd0, 1'b1, 2'd2, 16'h0123};
    vec[17] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 3'd0, 1'b0, ST,  3'd3, 1'b0, 16'h0210, 2'd0, 8'd1, 8'd1, 1'b1, 2'd2, 16'h0123};
    // Disable ch0 while it matches: counted once more, then silent.
    vec[18] = '{1'b0, 1'b1, 2'd0, 1'b0, ST,   3'd3, 1'b1, ST,  3'd3, 1'b1, 16'h0220, 2'd0, 8'd2, 8'd1, 1'b1, 2'd2, 16'h0123};
    vec[19] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 3'd0, 1'b0, ST,  3'd3, 1'b1, 16'h0230, 2'd0, 8'd2, 8'd1, 1'b1, 2'd2, 16'h0123};
    vec[20] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 3'd0, 1'b0, NOP, 3'd0, 1'b1, 16'h0000, 2'd3, 8'd0, 8'd0, 1'b1, 2'd2, 16'h0123};

    // Reset
    idle_in();
    rd_sel = 2'd0;
    rst_n  = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table
    for (int i = 0; i < NV; i++) begin
      idle_in();
      clr = vec[i].clr;
      cfg_we = vec[i].we; cfg_sel = vec[i].sel; cfg_en = vec[i].en;
      cfg_opc = vec[i].copc; cfg_step = vec[i].cstep; cfg_rw = vec[i].crw;
      drive_bus(vec[i].opc, vec[i].upc, vec[i].rw, vec[i].addr);
      rd_sel = vec[i].rsel;
      push(vec[i].e_pass, vec[i].e_fail, vec[i].e_err, vec[i].e_chan, vec[i].e_addr,
           $sformatf("vec%0d", i));
      tick();
      compare_head();
    end

    // Saturation: clear + re-enable ch0, then 300 passing events.
    idle_in();
    rd_sel = 2'd0;
    clr = 1'b1;
    drive_cfg(2'd0, 1'b1, ST, 3'd3, 1'b0);
    push(8'd0, 8'd0, 1'b0, 2'd0, 16'h0000, "sat_start");
    tick();
    compare_head();
    idle_in();
    for (int k = 1; k <= 300; k++) begin
      drive_bus(ST, 3'd3, 1'b0, 16'h0300);
      if (k == 254 || k == 255 || k == 256 || k == 300)
        push((k > 255) ? 8'd255 : 8'(k), 8'd0, 1'b0, 2'd0, 16'h0000, $sformatf("sat%0d", k));
      tick();
      if (k == 254 || k == 255 || k == 256 || k == 300) compare_head();
    end
    // clr beats a same-cycle match
    clr = 1'b1;
    drive_bus(ST, 3'd3, 1'b0, 16'h0310);
    push(8'd0, 8'd0, 1'b0, 2'd0, 16'h0000, "clr_vs_match");
    tick();
    compare_head();
    clr = 1'b0;

    // Mid-stream reset after two passes and one failure.
    for (int k = 1; k <= 2; k++) begin
      drive_bus(ST, 3'd3, 1'b0, 16'h0400);
      push(8'(k), 8'd0, 1'b0, 2'd0, 16'h0000, $sformatf("pre_rst%0d", k));
      tick();
      compare_head();
    end
    drive_bus(ST, 3'd3, 1'b1, 16'h0444);
    push(8'd2, 8'd1, 1'b1, 2'd0, 16'h0444, "pre_rst_fail");
    tick();
    compare_head();
    drive_bus(ST, 3'd3, 1'b1, 16'h0450);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive_bus(ST, 3'd3, 1'b1, 16'h0555);
    push(8'd0, 8'd0, 1'b0, 2'd0, 16'h0000, "post_rst");
    tick();
    compare_head();

    // Watchdog: enable ch0, then idle.
    idle_in();
    drive_cfg(2'd0, 1'b1, ST, 3'd3, 1'b0);
    tick();
    idle_in();
    repeat (63) tick();
    check("wd_idle63", wd_tmo, 0);
    tick();
    check("wd_idle64", wd_tmo, WD_EXP);
    $display("wd_idle64: wd_tmo=%0b", wd_tmo);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("wd_clr", wd_tmo, 0);
    repeat (40) tick();
    drive_bus(ST, 3'd3, 1'b0, 16'h0600);
    tick();
    idle_in();
    repeat (63) tick();
    check("wd_after_match63", wd_tmo, 0);
    tick();
    check("wd_after_match64", wd_tmo, WD_EXP);
    $display("wd_after_match64: wd_tmo=%0b", wd_tmo);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
